gb_cpu_bus_seq: RTL and testbench

- Parametrised M-cycle bus sequencer between the CPU core's execute logic and the external memory bus.
- Converts single-beat read, write and opcode-fetch requests from the core (valid/ready handshake) into timed strobe sequences of TSTATES clocks each.
- Returns read data or write acknowledge through a one-cycle response pulse.
- Replaces the fixed divide-by-4 fetch path, generalising bus width, T-states per M-cycle and back-to-back issue, with optional wait-state stretching.

---
 rtl/gb_cpu_bus_seq.sv | 157 +++++++++++++++
 tb/tb_gb_cpu_bus_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_bus_seq.sv
// M-cycle bus sequencer: turns single-beat core requests into timed rd_n/wr_n/m1_n strobe sequences.
// Optional wait-state stretching at the sample T-state is enabled with GB_BUS_WAIT_EN.
module gb_cpu_bus_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TSTATES = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_m1,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_n,
  output logic              wr_n,
  output logic              m1_n,
  output logic              busy,
  output logic [CNT_W-1:0]  mcyc_cnt
`ifdef GB_BUS_WAIT_EN
  ,
  input  logic              wait_n
`endif
);

  localparam int            TW     = $clog2(TSTATES);
  localparam logic [TW-1:0] T_LAST = TW'(TSTATES - 1);
  localparam logic [TW-1:0] T_SAMP = TW'(TSTATES - 2);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          cmd_we_q, cmd_we_d;
  logic          cmd_m1_q, cmd_m1_d;

  logic          wait_ok;
  logic          last_t;
  logic          stretch;
  logic          accept;
  logic          sample_t;

  logic          rd_n_d, wr_n_d, m1_n_d, rsp_valid_d;

`ifdef GB_BUS_WAIT_EN
  assign wait_ok = wait_n;
`else
  assign wait_ok = 1'b1;
`endif

  assign last_t    = (state_q == S_ACTIVE) && (tcnt_q == T_LAST);
  assign stretch   = (state_q == S_ACTIVE) && (tcnt_q == T_SAMP) && !wait_ok;
  assign req_ready = (state_q == S_IDLE) || (last_t && !stretch);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == S_ACTIVE);

  // Read data is captured on the first edge leaving the sample T-state without a wait request.
  assign sample_t  = (state_q == S_ACTIVE) && (tcnt_q == T_SAMP) && wait_ok && !cmd_we_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop sees pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      cmd_we_q <= 1'b0;
      cmd_m1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      cmd_we_q <= cmd_we_d;
      cmd_m1_q <= cmd_m1_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    cmd_we_d = cmd_we_q;
    cmd_m1_d = cmd_m1_q;
    if (accept) begin
      state_d  = S_ACTIVE;
      tcnt_d   = '0;
      cmd_we_d = req_we;
      cmd_m1_d = req_m1 && !req_we;
    end else if (state_q == S_ACTIVE) begin
      if (last_t) begin
        state_d = S_IDLE;
        tcnt_d  = '0;
      end else if (!stretch) begin
        tcnt_d = tcnt_q + T_ONE;
      end
    end
  end

  // Strobes are decoded from the next state and registered, so the pins come straight off flops.
  always_comb begin
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    m1_n_d      = 1'b1;
    rsp_valid_d = 1'b0;
    if (state_d == S_ACTIVE) begin
      if (!cmd_we_d && (tcnt_d <= T_SAMP)) begin
        rd_n_d = 1'b0;
      end
      if (cmd_we_d && (tcnt_d >= T_ONE) && (tcnt_d <= T_SAMP)) begin
        wr_n_d = 1'b0;
      end
      if (cmd_m1_d && (tcnt_d <= T_ONE)) begin
        m1_n_d = 1'b0;
      end
      rsp_valid_d = (tcnt_d == T_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      m1_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr      <= '0;
      data_out  <= '0;
      mcyc_cnt  <= '0;
    end else begin
      rd_n      <= rd_n_d;
      wr_n      <= wr_n_d;
      m1_n      <= m1_n_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        addr <= req_addr;
      end
      if (accept && req_we) begin
        data_out <= req_wdata;
      end
      if (sample_t) begin
        rsp_rdata <= data_in;
      end
      if (last_t) begin
        mcyc_cnt <= mcyc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gb_cpu_bus_seq.sv
// Self-checking bench for gb_cpu_bus_seq: directed scenarios plus random traffic against a
// cycle-timeline reference model; the wait-state scenario is built only with GB_BUS_WAIT_EN.
module tb_gb_cpu_bus_seq;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int TS   = 4;
  localparam int CW   = 5;
  localparam int NCYC = 4096;
  localparam int NRND = 150;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_m1;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          rd_n;
  logic          wr_n;
  logic          m1_n;
  logic          busy;
  logic [CW-1:0] mcyc_cnt;
`ifdef GB_BUS_WAIT_EN
  logic          wait_n;
`endif

  always #5 clk = ~clk;

  gb_cpu_bus_seq #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TSTATES(TS),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_m1   (req_m1),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .addr     (addr),
    .data_out (data_out),
    .data_in  (data_in),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .m1_n     (m1_n),
    .busy     (busy),
    .mcyc_cnt (mcyc_cnt)
`ifdef GB_BUS_WAIT_EN
    ,
    .wait_n   (wait_n)
`endif
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Expected timeline, one slot per clock period, painted when a request is accepted.
  bit            e_busy[NCYC];
  bit            e_notready[NCYC];
  bit            e_rdlow[NCYC];
  bit            e_wrlow[NCYC];
  bit            e_m1low[NCYC];
  bit            e_rsp[NCYC];
  bit            e_rdv[NCYC];
  bit            e_addr_upd[NCYC];
  bit            e_dout_upd[NCYC];
  bit            e_cnt_inc[NCYC];
  bit            e_reset[NCYC];
  logic [DW-1:0] e_rdata[NCYC];
  logic [DW-1:0] e_dout_val[NCYC];
  logic [AW-1:0] e_addr_val[NCYC];
  logic [DW-1:0] dhist[NCYC];

  logic [AW-1:0] cur_addr  = '0;
  logic [DW-1:0] cur_dout  = '0;
  logic [DW-1:0] cur_rdata = '0;
  logic [CW-1:0] cur_cnt   = '0;

  int cyc = 0;
  int acc_cyc = 0;
  bit model_on = 1'b1;
  int n_rd_low, n_wr_low, n_m1_low, n_rsp, n_busy;
  int rsp_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_rd_low = 0;
    n_wr_low = 0;
    n_m1_low = 0;
    n_rsp    = 0;
    n_busy   = 0;
    rsp_cyc_q.delete();
  endtask

  task automatic clear_from(input int from);
    for (int q = from; q < NCYC; q++) begin
      e_busy[q]     = 1'b0;
      e_notready[q] = 1'b0;
      e_rdlow[q]    = 1'b0;
      e_wrlow[q]    = 1'b0;
      e_m1low[q]    = 1'b0;
      e_rsp[q]      = 1'b0;
      e_rdv[q]      = 1'b0;
      e_addr_upd[q] = 1'b0;
      e_dout_upd[q] = 1'b0;
      e_cnt_inc[q]  = 1'b0;
      e_reset[q]    = 1'b0;
    end
  endtask

  // A request accepted at the end of period p occupies periods p+1 .. p+TS.
  task automatic paint(input int p, input bit we, input bit m1,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    for (int j = 0; j < TS; j++) begin
      e_busy[p+1+j]     = 1'b1;
      e_notready[p+1+j] = (j != TS - 1);
      e_rdlow[p+1+j]    = !we && (j <= TS - 2);
      e_wrlow[p+1+j]    = we && (j >= 1) && (j <= TS - 2);
      e_m1low[p+1+j]    = !we && m1 && (j <= 1);
    end
    e_addr_upd[p+1] = 1'b1;
    e_addr_val[p+1] = a;
    if (we) begin
      e_dout_upd[p+1] = 1'b1;
      e_dout_val[p+1] = wd;
    end else begin
      e_rdv[p+TS]   = 1'b1;
      e_rdata[p+TS] = dhist[p+TS-1];
    end
    e_rsp[p+TS]       = 1'b1;
    e_cnt_inc[p+TS+1] = 1'b1;
  endtask

  task automatic observe(input int q);
    if (e_reset[q]) begin
      cur_addr  = '0;
      cur_dout  = '0;
      cur_rdata = '0;
      cur_cnt   = '0;
    end
    if (e_addr_upd[q]) cur_addr = e_addr_val[q];
    if (e_dout_upd[q]) cur_dout = e_dout_val[q];
    if (e_rdv[q]) cur_rdata = e_rdata[q];
    if (e_cnt_inc[q]) cur_cnt = cur_cnt + 1'b1;
    if (!rd_n) n_rd_low++;
    if (!wr_n) n_wr_low++;
    if (!m1_n) n_m1_low++;
    if (busy) n_busy++;
    if (rsp_valid) begin
      n_rsp++;
      rsp_cyc_q.push_back(q);
    end
    if (model_on) begin
      check($sformatf("rd_n@%0d", q), rd_n, !e_rdlow[q]);
      check($sformatf("wr_n@%0d", q), wr_n, !e_wrlow[q]);
      check($sformatf("m1_n@%0d", q), m1_n, !e_m1low[q]);
      check($sformatf("busy@%0d", q), busy, e_busy[q]);
      check($sformatf("req_ready@%0d", q), req_ready, !e_notready[q]);
      check($sformatf("rsp_valid@%0d", q), rsp_valid, e_rsp[q]);
      check($sformatf("rsp_rdata@%0d", q), rsp_rdata, cur_rdata);
      check($sformatf("addr@%0d", q), addr, cur_addr);
      check($sformatf("data_out@%0d", q), data_out, cur_dout);
      check($sformatf("mcyc_cnt@%0d", q), mcyc_cnt, cur_cnt);
    end
  endtask

  // Close the current period: record what the next edge will do, then move to the next period.
  task automatic tick();
    bit acc;
    acc = req_valid && req_ready && !rst;
    if (rst) begin
      clear_from(cyc + 1);
      e_reset[cyc+1] = 1'b1;
    end else if (acc) begin
      paint(cyc, req_we, req_m1, req_addr, req_wdata);
      acc_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
    if (cyc >= NCYC - TS - 2) begin
      $display("FAIL cycle_budget: reached period %0d, limit %0d", cyc, NCYC - TS - 2);
      $fatal(1);
    end
    data_in = dhist[cyc];
    observe(cyc);
  endtask

  task automatic issue(input bit we, input bit m1, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    int n;
    bit acc;
    n         = 0;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_m1    = m1;
    req_addr  = a;
    req_wdata = wd;
    while (!acc && n < 64) begin
      acc = req_ready;
      tick();
      n++;
    end
    check("accept_within_bound", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int cnt_before;
    for (int q = 0; q < NCYC; q++) dhist[q] = DW'($urandom);
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_m1    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    data_in   = dhist[0];
`ifdef GB_BUS_WAIT_EN
    wait_n    = 1'b1;
`endif

    // Reset, then idle.
    repeat (3) tick();
    rst = 1'b0;
    clear_stats();
    idle(5);
    check("idle_rd_n", rd_n, 1'b1);
    check("idle_wr_n", wr_n, 1'b1);
    check("idle_m1_n", m1_n, 1'b1);
    check("idle_req_ready", req_ready, 1'b1);
    check("idle_mcyc_cnt", mcyc_cnt, 0);
    check("idle_busy", busy, 1'b0);
    check("idle_busy_cycles", n_busy, 0);
    check("idle_addr", addr, 0);
    check("idle_data_out", data_out, 0);
    check("idle_rsp_rdata", rsp_rdata, 0);

    // Opcode fetch from 0x0100 returning 0x3E.
    for (int q = cyc + 1; q < cyc + TS + 8; q++) dhist[q] = 8'h3E;
    clear_stats();
    issue(1'b0, 1'b1, 16'h0100, 8'h00);
    idle(TS + 1);
    check("fetch_rd_low_clocks", n_rd_low, TS - 1);
    check("fetch_m1_low_clocks", n_m1_low, 2);
    check("fetch_wr_low_clocks", n_wr_low, 0);
    check("fetch_rsp_pulses", n_rsp, 1);
    check("fetch_rsp_latency", rsp_cyc_q[0] - acc_cyc, TS);
    check("fetch_rsp_rdata", rsp_rdata, 8'h3E);
    check("fetch_mcyc_cnt", mcyc_cnt, 1);
    check("fetch_busy_clocks", n_busy, TS);

    // Write 0xA5 to 0xFF80.
    clear_stats();
    issue(1'b1, 1'b1, 16'hFF80, 8'hA5);
    idle(TS + 1);
    check("write_wr_low_clocks", n_wr_low, TS - 2);
    check("write_rd_low_clocks", n_rd_low, 0);
    check("write_m1_low_clocks", n_m1_low, 0);
    check("write_rsp_pulses", n_rsp, 1);
    check("write_rsp_latency", rsp_cyc_q[0] - acc_cyc, TS);
    check("write_data_out", data_out, 8'hA5);
    check("write_addr", addr, 16'hFF80);
    check("write_rsp_rdata_held", rsp_rdata, 8'h3E);
    check("write_mcyc_cnt", mcyc_cnt, 2);

    // Three back-to-back reads with req_valid held high.
    clear_stats();
    issue(1'b0, 1'b0, 16'hC000, 8'h00);
    issue(1'b0, 1'b0, 16'hC001, 8'h00);
    issue(1'b0, 1'b0, 16'hC002, 8'h00);
    idle(TS + 1);
    check("b2b_busy_clocks", n_busy, 3 * TS);
    check("b2b_rsp_pulses", n_rsp, 3);
    check("b2b_rsp_gap_1", rsp_cyc_q[1] - rsp_cyc_q[0], TS);
    check("b2b_rsp_gap_2", rsp_cyc_q[2] - rsp_cyc_q[1], TS);
    check("b2b_mcyc_cnt", mcyc_cnt, 5);
    check("b2b_last_addr", addr, 16'hC002);

    // Reset asserted at tcnt=1 of a read.
    clear_stats();
    issue(1'b0, 1'b0, 16'h1234, 8'h00);
    req_valid = 1'b0;
    tick();
    check("midrst_rd_active", rd_n, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rd_n", rd_n, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_mcyc_cnt", mcyc_cnt, 0);
    check("midrst_req_ready", req_ready, 1'b1);
    idle(TS + 1);
    check("midrst_no_rsp", n_rsp, 0);
    clear_stats();
    issue(1'b0, 1'b0, 16'h2000, 8'h00);
    idle(TS + 1);
    check("after_rst_rsp_pulses", n_rsp, 1);
    check("after_rst_mcyc_cnt", mcyc_cnt, 1);

    // Random traffic with random gaps, including zero-bubble issue and counter wrap.
    cnt_before = int'(cur_cnt);
    clear_stats();
    for (int i = 0; i < NRND; i++) begin
      int gap;
      gap = int'($urandom_range(0, TS + 2));
      if (gap > 0) idle(gap);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    end
    idle(TS + 2);
    check("rand_rsp_pulses", n_rsp, NRND);
    check("rand_mcyc_wrap", mcyc_cnt, (cnt_before + NRND) % (1 << CW));

`ifdef GB_BUS_WAIT_EN
    // Read stretched by three wait clocks at the sample T-state.
    model_on = 1'b0;
    clear_stats();
    issue(1'b0, 1'b0, 16'h3000, 8'h00);
    for (int q = cyc + 1; q < cyc + TS + 8; q++) dhist[q] = 8'h11;
    req_valid = 1'b0;
    repeat (TS - 2) tick();
    wait_n = 1'b0;
    repeat (3) tick();
    wait_n   = 1'b1;
    data_in  = 8'h77;
    dhist[cyc] = 8'h77;
    tick();
    check("wait_rsp_valid", rsp_valid, 1'b1);
    check("wait_rsp_rdata", rsp_rdata, 8'h77);
    idle(3);
    check("wait_busy_clocks", n_busy, TS + 3);
    check("wait_rd_low_clocks", n_rd_low, TS - 1 + 3);
    check("wait_rsp_pulses", n_rsp, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
